// File: rtl/wb_dbg_pkg.sv
// Shared types and constants for the Wishbone debug bridge.
// Holds the FSM encoding, error data pattern, slave indices and saturating increment.
package wb_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int          SLV_DBG  = 0;
  localparam int          SLV_USR  = 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Wait-cycle counter for the bridge REQ phase.
// Flags expiry once the count reaches limit-1.
module wb_timeout_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (enable) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = (count_q == (limit - 8'd1));

endmodule

// File: rtl/wb_dbg_bridge.sv
// Wishbone classic 1-to-2 bridge with address decode, slave timeout and error counting.
// Unmapped accesses and timeouts answer with ERR_DATA and bump a saturating error count.
module wb_dbg_bridge #(
  parameter logic [31:0] DBG_BASE       = 32'h3000_0000,
  parameter logic [31:0] USR_BASE       = 32'h3000_1000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [1:0]  m_cyc_o,
  output logic [1:0]  m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [1:0]  m_ack_i,
  input  logic [31:0] m_dat0_i,
  input  logic [31:0] m_dat1_i,
  output logic [7:0]  err_cnt_o
);
  import wb_dbg_pkg::*;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e      state_q;
  logic [1:0]  m_strb_q;
  logic        m_we_q;
  logic [3:0]  m_sel_q;
  logic [31:0] m_adr_q;
  logic [31:0] m_dat_q;
  logic        slv_q;
  logic        wbs_ack_q;
  logic [31:0] wbs_dat_q;
  logic [7:0]  err_cnt_q;

  logic        hit_dbg;
  logic        hit_usr;
  logic        sel_ack;
  logic        expired;
  logic [31:0] slv_rdata;

  assign hit_dbg   = (wbs_adr_i[31:12] == DBG_BASE[31:12]);
  assign hit_usr   = (wbs_adr_i[31:12] == USR_BASE[31:12]);
  assign sel_ack   = m_ack_i[slv_q];
  assign slv_rdata = slv_q ? m_dat1_i : m_dat0_i;

  wb_timeout_cnt u_timeout (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n),
    .clear   (state_q != ST_REQ),
    .enable  ((state_q == ST_REQ) && !sel_ack),
    .limit   (TO_LIMIT),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= ST_IDLE;
      m_strb_q  <= 2'b00;
      m_we_q    <= 1'b0;
      m_sel_q   <= 4'h0;
      m_adr_q   <= 32'h0;
      m_dat_q   <= 32'h0;
      slv_q     <= 1'b0;
      wbs_ack_q <= 1'b0;
      wbs_dat_q <= 32'h0;
      err_cnt_q <= 8'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            m_we_q  <= wbs_we_i;
            m_sel_q <= wbs_sel_i;
            m_adr_q <= wbs_adr_i;
            m_dat_q <= wbs_dat_i;
            if (hit_dbg) begin
              slv_q    <= 1'(SLV_DBG);
              m_strb_q <= 2'b01;
              state_q  <= ST_REQ;
            end else if (hit_usr) begin
              slv_q    <= 1'(SLV_USR);
              m_strb_q <= 2'b10;
              state_q  <= ST_REQ;
            end else begin
              err_cnt_q <= sat_inc8(err_cnt_q);
              state_q   <= ST_RESP;
            end
          end
        end
        ST_REQ: begin
          // Abort beats ack; ack beats timeout.
          if (!wbs_cyc_i) begin
            m_strb_q <= 2'b00;
            state_q  <= ST_IDLE;
          end else if (sel_ack) begin
            m_strb_q  <= 2'b00;
            wbs_ack_q <= 1'b1;
            wbs_dat_q <= m_we_q ? 32'h0 : slv_rdata;
            state_q   <= ST_RESP;
          end else if (expired) begin
            m_strb_q  <= 2'b00;
            wbs_ack_q <= 1'b1;
            wbs_dat_q <= ERR_DATA;
            err_cnt_q <= sat_inc8(err_cnt_q);
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Unmapped accesses arrive with ack low and spend one extra cycle here.
          if (wbs_ack_q) begin
            wbs_ack_q <= 1'b0;
            wbs_dat_q <= 32'h0;
            state_q   <= ST_IDLE;
          end else begin
            wbs_ack_q <= 1'b1;
            wbs_dat_q <= ERR_DATA;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_cyc_o   = m_strb_q;
  assign m_stb_o   = m_strb_q;
  assign m_we_o    = m_we_q;
  assign m_sel_o   = m_sel_q;
  assign m_adr_o   = m_adr_q;
  assign m_dat_o   = m_dat_q;
  assign wbs_ack_o = wbs_ack_q;
  assign wbs_dat_o = wbs_dat_q;
  assign err_cnt_o = err_cnt_q;

endmodule
